// File: rtl/uart_result_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// uart_result_arbiter_pkg : shared state encoding and byte-index sizing
// Revision: 1.0
// ============================================================================
package uart_result_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } state_t;

  localparam int W_DEFAULT     = 32;
  localparam int NB_DEFAULT    = W_DEFAULT / 8;
  localparam int IDX_W_DEFAULT = $clog2(NB_DEFAULT);

  function automatic int idx_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_serializer.sv
`default_nettype none
// ============================================================================
// uart_byte_serializer : holds one result word and streams it LSB first
// Revision: 1.0
// ============================================================================
module uart_byte_serializer
  import uart_result_arbiter_pkg::*;
#(
  parameter int W  = 32,
  parameter int NB = W / 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         in_wait,
  input  logic         tx_done,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         frame_done
);

  localparam int IW = idx_width(NB);

  logic [W-1:0]  holding_q, holding_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          w_last;
  logic          w_advance;
  logic [IW-1:0] w_idx_nxt;

  assign w_last     = (idx_q == IW'(NB - 1));
  assign w_advance  = in_wait & tx_done & ~w_last;
  assign frame_done = in_wait & tx_done & w_last;
  assign w_idx_nxt  = idx_q + 1'b1;

  // Next byte is selected one cycle early so TX_DATA is registered with TX_START.
  always_comb begin
    holding_d  = holding_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (load) begin
      holding_d  = load_data;
      idx_d      = '0;
      tx_start_d = 1'b1;
      tx_data_d  = load_data[7:0];
    end else if (w_advance) begin
      idx_d      = w_idx_nxt;
      tx_start_d = 1'b1;
      tx_data_d  = holding_q[{w_idx_nxt, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding_q  <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      holding_q  <= holding_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
`default_nettype wire

// File: rtl/uart_result_arbiter.sv
`default_nettype none
// ============================================================================
// uart_result_arbiter : round-robin arbiter sending two requesters' results
// over a byte-wide UART transmitter.  Revision: 1.0
// ============================================================================
module uart_result_arbiter
  import uart_result_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_0,
  input  logic [W-1:0] data_0,
  input  logic         req_1,
  input  logic [W-1:0] data_1,
  output logic         ack_0,
  output logic         ack_1,
  output logic         TX_START,
  output logic [7:0]   TX_DATA,
  input  logic         TX_DONE,
  output logic         busy,
  output logic         grant,
  output logic [15:0]  frame_cnt
);

  localparam int NB = W / 8;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          last_q, last_d;
  logic [1:0]    ack_q, ack_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic          w_load;
  logic [W-1:0]  w_load_data;
  logic          w_frame_done;
  logic          w_req_g;

  assign w_req_g = grant_q ? req_1 : req_0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    last_d      = last_q;
    ack_d       = ack_q;
    frame_cnt_d = frame_cnt_q;
    w_load      = 1'b0;
    w_load_data = data_0;
    case (state_q)
      ST_IDLE: begin
        if (req_0 | req_1) begin
          // On a tie the requester not served last wins.
          grant_d     = (req_0 & req_1) ? ~last_q : req_1;
          w_load      = 1'b1;
          w_load_data = grant_d ? data_1 : data_0;
          busy_d      = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (w_frame_done) begin
          state_d     = ST_ACK;
          frame_cnt_d = frame_cnt_q + 16'd1;
          ack_d       = grant_q ? 2'b10 : 2'b01;
        end else if (TX_DONE) begin
          state_d = ST_SEND;
        end
      end
      ST_ACK: begin
        if (!w_req_g) begin
          state_d = ST_IDLE;
          ack_d   = 2'b00;
          busy_d  = 1'b0;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b1;
      ack_q       <= 2'b00;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  uart_byte_serializer #(
    .W  (W),
    .NB (NB)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_data  (w_load_data),
    .in_wait    (state_q == ST_WAIT_DONE),
    .tx_done    (TX_DONE),
    .tx_start   (TX_START),
    .tx_data    (TX_DATA),
    .frame_done (w_frame_done)
  );

  assign ack_0     = ack_q[0];
  assign ack_1     = ack_q[1];
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_result_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_result_arbiter : directed bench for the W=32 and W=64 arbiter
// Revision: 1.0
// ============================================================================
module tb_uart_result_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1, tx_done;
  logic [31:0] data_0, data_1;
  logic        ack_0, ack_1, tx_start, busy, grant;
  logic [7:0]  tx_data;
  logic [15:0] frame_cnt;

  logic        req64;
  logic [63:0] data64;
  logic        a64_0, a64_1, start64, busy64, grant64;
  logic [7:0]  txd64;
  logic [15:0] fc64;

  logic        sel = 1'b0;
  logic        w_start;
  logic [7:0]  w_txd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign w_start = sel ? start64 : tx_start;
  assign w_txd   = sel ? txd64 : tx_data;

  uart_result_arbiter #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .req_0(req_0), .data_0(data_0), .req_1(req_1), .data_1(data_1),
    .ack_0(ack_0), .ack_1(ack_1), .TX_START(tx_start), .TX_DATA(tx_data), .TX_DONE(tx_done),
    .busy(busy), .grant(grant), .frame_cnt(frame_cnt)
  );

  uart_result_arbiter #(.W(64)) dut64 (
    .clk(clk), .rst(rst), .req_0(req64), .data_0(data64), .req_1(1'b0), .data_1(64'h0),
    .ack_0(a64_0), .ack_1(a64_1), .TX_START(start64), .TX_DATA(txd64), .TX_DONE(tx_done),
    .busy(busy64), .grant(grant64), .frame_cnt(fc64)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acts as the UART: answers each TX_START with TX_DONE ten cycles later.
  task automatic serve_frame(input int nbytes, input logic [63:0] data, input int drop_at);
    int w;
    for (int b = 0; b < nbytes; b++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (b == drop_at) req_0 = 1'b0;
      w = 0;
      while (!w_start && w < 50) begin
        @(negedge clk);
        w++;
      end
      check_eq("start_latency", 64'(w), 64'd0);
      check_eq("tx_data", {56'h0, w_txd}, {56'h0, data[8*b +: 8]});
      @(negedge clk);
      check_eq("start_strobe", {63'h0, w_start}, 64'd0);
      repeat (9) @(negedge clk);
      check_eq("tx_data_stable", {56'h0, w_txd}, {56'h0, data[8*b +: 8]});
      tx_done = 1'b1;
    end
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_0 = 0; req_1 = 0; tx_done = 0; data_0 = 0; data_1 = 0;
    req64 = 0; data64 = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'h0, busy}, 0);
    check_eq("rst_grant", {63'h0, grant}, 0);
    check_eq("rst_start", {63'h0, tx_start}, 0);
    check_eq("rst_txdata", {56'h0, tx_data}, 0);
    check_eq("rst_acks", {62'h0, ack_1, ack_0}, 0);
    check_eq("rst_cnt", {48'h0, frame_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single request
    req_0 = 1; data_0 = 32'hA1B2C3D4;
    serve_frame(4, 64'hA1B2C3D4, -1);
    check_eq("single_ack", {62'h0, ack_1, ack_0}, 64'b01);
    check_eq("single_cnt", {48'h0, frame_cnt}, 1);
    check_eq("single_busy", {63'h0, busy}, 1);
    req_0 = 0;
    @(negedge clk);
    check_eq("single_release", {62'h0, ack_1, ack_0}, 0);
    check_eq("single_idle", {63'h0, busy}, 0);

    // Round-robin ties after a fresh reset
    rst = 1; @(negedge clk); rst = 0; @(negedge clk);
    req_0 = 1; req_1 = 1; data_0 = 32'h11223344; data_1 = 32'h55667788;
    serve_frame(4, 64'h11223344, -1);
    check_eq("tie1_grant", {63'h0, grant}, 0);
    check_eq("tie1_ack", {62'h0, ack_1, ack_0}, 64'b01);
    req_0 = 0;
    @(negedge clk);
    check_eq("tie1_release", {62'h0, ack_1, ack_0}, 0);
    req_0 = 1; data_0 = 32'h99AABBCC;
    serve_frame(4, 64'h55667788, -1);
    check_eq("tie2_grant", {63'h0, grant}, 1);
    check_eq("tie2_ack", {62'h0, ack_1, ack_0}, 64'b10);
    tx_done = 1; @(negedge clk); tx_done = 0; @(negedge clk);
    check_eq("ack_stray_start", {63'h0, tx_start}, 0);
    check_eq("ack_stray_hold", {62'h0, ack_1, ack_0}, 64'b10);
    check_eq("ack_stray_cnt", {48'h0, frame_cnt}, 2);
    req_1 = 0;
    @(negedge clk);
    req_1 = 1;
    serve_frame(4, 64'h99AABBCC, -1);
    check_eq("tie3_grant", {63'h0, grant}, 0);
    check_eq("tie3_cnt", {48'h0, frame_cnt}, 3);
    req_0 = 0; req_1 = 0;
    @(negedge clk); @(negedge clk);

    // Granted requester drops mid-frame
    req_0 = 1; data_0 = 32'hDEADBEEF;
    serve_frame(4, 64'hDEADBEEF, 1);
    check_eq("drop_ack", {62'h0, ack_1, ack_0}, 64'b01);
    check_eq("drop_cnt", {48'h0, frame_cnt}, 4);
    @(negedge clk);
    check_eq("drop_idle", {63'h0, busy}, 0);

    // Stray TX_DONE in IDLE
    tx_done = 1; @(negedge clk); tx_done = 0; @(negedge clk);
    check_eq("idle_stray_start", {63'h0, tx_start}, 0);
    check_eq("idle_stray_busy", {63'h0, busy}, 0);
    check_eq("idle_stray_cnt", {48'h0, frame_cnt}, 4);

    // Reset after byte 2 while byte 3 is being started
    req_0 = 1; data_0 = 32'h01020304;
    serve_frame(2, 64'h01020304, -1);
    rst = 1; req_0 = 0;
    #1;
    check_eq("mid_rst_start", {63'h0, tx_start}, 0);
    check_eq("mid_rst_busy", {63'h0, busy}, 0);
    check_eq("mid_rst_ack", {62'h0, ack_1, ack_0}, 0);
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_start", {63'h0, tx_start}, 0);
    req_0 = 1; data_0 = 32'hCAFEF00D;
    serve_frame(4, 64'hCAFEF00D, -1);
    check_eq("post_rst_cnt", {48'h0, frame_cnt}, 1);
    req_0 = 0;
    @(negedge clk);

    // 64-bit instance
    sel = 1; req64 = 1; data64 = 64'h0102030405060708;
    serve_frame(8, 64'h0102030405060708, -1);
    check_eq("w64_ack", {62'h0, a64_1, a64_0}, 64'b01);
    check_eq("w64_cnt", {48'h0, fc64}, 1);
    req64 = 0;
    @(negedge clk);
    check_eq("w64_release", {62'h0, a64_1, a64_0}, 0);
    sel = 0;

    // Frame counter wrap
    force dut32.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut32.frame_cnt_q;
    @(negedge clk);
    check_eq("wrap_preload", {48'h0, frame_cnt}, 64'hFFFF);
    req_0 = 1; data_0 = 32'h0BADCAFE;
    serve_frame(4, 64'h0BADCAFE, -1);
    check_eq("wrap_cnt", {48'h0, frame_cnt}, 0);
    req_0 = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
